// File: rtl/square_wave_seq_if.sv
// Control-side bundle for the square wave sequencer.
// slave  : sequencer view (table write, program control in; generator drive and status out)
// master : control/register logic view (the mirror of slave)
interface square_wave_seq_if #(
  parameter int unsigned PW = 4,
  parameter int unsigned RW = 4
);
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [PW-1:0] wr_on;
  logic [PW-1:0] wr_off;
  logic [RW-1:0] wr_rep;
  logic [1:0]    last;
  logic          loop;
  logic          start;
  logic          stop;
  logic [PW-1:0] on_period;
  logic [PW-1:0] off_period;
  logic          gen_reset;
  logic          busy;
  logic          done;
  logic [1:0]    cur_entry;

  modport slave (
    input  wr_en, wr_addr, wr_on, wr_off, wr_rep, last, loop, start, stop,
    output on_period, off_period, gen_reset, busy, done, cur_entry
  );

  modport master (
    output wr_en, wr_addr, wr_on, wr_off, wr_rep, last, loop, start, stop,
    input  on_period, off_period, gen_reset, busy, done, cur_entry
  );
endinterface

// File: rtl/square_wave_seq.sv
// Square wave generator sequencer.
// Plays a 4-entry program table of (on, off, repeat) entries into the generator,
// holding each entry for repeat*(on+off)*TICK cycles and re-phasing the generator
// with a one-cycle gen_reset pulse (the LOAD cycle) at every entry change.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset (also clears the table)
//   bus   - slave modport: table write, last/loop/start/stop in;
//           on_period/off_period/gen_reset to generator, busy/done/cur_entry status out
module square_wave_seq #(
  parameter int unsigned PW   = 4,
  parameter int unsigned RW   = 4,
  parameter int unsigned TICK = 10,
  parameter int unsigned CW   = 12
) (
  input  logic              clk,
  input  logic              reset,
  square_wave_seq_if.slave  bus
);

  localparam int unsigned NENT = 4;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    last_q, last_d;
  logic          loop_q, loop_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [RW-1:0] rep_q, rep_d;

  logic [PW-1:0] on_tbl_q  [NENT];
  logic [PW-1:0] on_tbl_d  [NENT];
  logic [PW-1:0] off_tbl_q [NENT];
  logic [PW-1:0] off_tbl_d [NENT];
  logic [RW-1:0] rep_tbl_q [NENT];
  logic [RW-1:0] rep_tbl_d [NENT];

  logic [PW-1:0] on_q, on_d;
  logic [PW-1:0] off_q, off_d;
  logic          gen_rst_q, gen_rst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1:0]    cur_q, cur_d;

  logic          enter_load;
  logic          end_entry;
  logic          goto_idle;

  // Dwell reload value for one on+off period: (on+off)*TICK-1 in CW bits.
  function automatic logic [CW-1:0] dwell_of(input logic [PW-1:0] on_v,
                                             input logic [PW-1:0] off_v);
    return CW'((CW'(on_v) + CW'(off_v)) * CW'(TICK)) - CW'(1);
  endfunction

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    loop_d     = loop_q;
    dwell_d    = dwell_q;
    rep_d      = rep_q;
    on_tbl_d   = on_tbl_q;
    off_tbl_d  = off_tbl_q;
    rep_tbl_d  = rep_tbl_q;
    on_d       = on_q;
    off_d      = off_q;
    gen_rst_d  = gen_rst_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cur_d      = cur_q;
    enter_load = 1'b0;
    end_entry  = 1'b0;
    goto_idle  = 1'b0;

    // Writes land before the load mux so a same-cycle start sees the new entry.
    if (state_q == S_IDLE && bus.wr_en) begin
      on_tbl_d[bus.wr_addr]  = bus.wr_on;
      off_tbl_d[bus.wr_addr] = bus.wr_off;
      rep_tbl_d[bus.wr_addr] = bus.wr_rep;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          enter_load = 1'b1;
          idx_d      = 2'd0;
          last_d     = bus.last;
          loop_d     = bus.loop;
        end
      end
      S_LOAD: begin
        if (bus.stop) begin
          goto_idle = 1'b1;
        end else if (rep_q == '0 || (on_q == '0 && off_q == '0)) begin
          end_entry = 1'b1;
        end else begin
          state_d   = S_RUN;
          gen_rst_d = 1'b0;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          goto_idle = 1'b1;
        end else if (dwell_q == '0) begin
          if (rep_q > RW'(1)) begin
            rep_d   = rep_q - RW'(1);
            dwell_d = dwell_of(on_q, off_q);
          end else begin
            end_entry = 1'b1;
          end
        end else begin
          dwell_d = dwell_q - CW'(1);
        end
      end
      S_DONE: begin
        goto_idle = 1'b1;
      end
      default: begin
        goto_idle = 1'b1;
      end
    endcase

    if (end_entry) begin
      if (idx_q < last_q) begin
        enter_load = 1'b1;
        idx_d      = idx_q + 2'd1;
      end else if (loop_q) begin
        enter_load = 1'b1;
        idx_d      = 2'd0;
      end else begin
        state_d   = S_DONE;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        gen_rst_d = 1'b1;
        on_d      = '0;
        off_d     = '0;
      end
    end

    if (goto_idle) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      gen_rst_d = 1'b1;
      on_d      = '0;
      off_d     = '0;
    end

    if (enter_load) begin
      state_d   = S_LOAD;
      cur_d     = idx_d;
      on_d      = on_tbl_d[idx_d];
      off_d     = off_tbl_d[idx_d];
      rep_d     = rep_tbl_d[idx_d];
      dwell_d   = dwell_of(on_tbl_d[idx_d], off_tbl_d[idx_d]);
      gen_rst_d = 1'b1;
      busy_d    = 1'b1;
    end
  end

  // State, table and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      dwell_q   <= '0;
      rep_q     <= '0;
      for (int i = 0; i < NENT; i++) begin
        on_tbl_q[i]  <= '0;
        off_tbl_q[i] <= '0;
        rep_tbl_q[i] <= '0;
      end
      on_q      <= '0;
      off_q     <= '0;
      gen_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cur_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      loop_q    <= loop_d;
      dwell_q   <= dwell_d;
      rep_q     <= rep_d;
      on_tbl_q  <= on_tbl_d;
      off_tbl_q <= off_tbl_d;
      rep_tbl_q <= rep_tbl_d;
      on_q      <= on_d;
      off_q     <= off_d;
      gen_rst_q <= gen_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cur_q     <= cur_d;
    end
  end

  assign bus.on_period  = on_q;
  assign bus.off_period = off_q;
  assign bus.gen_reset  = gen_rst_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cur_entry  = cur_q;

endmodule
